// File: rtl/plen_sched_pkg.sv
// plen_sched shared types: block geometry, slot fields, block descriptor.
// Also imported by the pidx bench models.
package plen_pkg;

  localparam int VLEN = 256;
  localparam int BSW  = 5;
  localparam int BS   = 1 << BSW;
  localparam int BLEN = VLEN / BS;
  localparam int WW   = 8 - BSW + 1;

  typedef logic [WW-1:0]  len_t;
  typedef logic [BSW-1:0] pos_t;
  typedef logic [BSW:0]   cnt_t;

  typedef enum logic {
    ACC,
    TAIL
  } state_t;

  typedef struct packed {
    cnt_t            inum;
    len_t [BS-1:0]   ilen;
    pos_t [BS-1:0]   ipos;
    cnt_t [BS-1:0]   psum;
    logic            last;
  } blk_t;

endpackage

// File: rtl/plen_sched_if.sv
// Field-length input and block-descriptor output handshakes
// of plen_sched.
interface plen_sched_if;
  import plen_pkg::*;

  logic          in_valid;
  logic          in_ready;
  len_t          in_len;
  logic          in_last;

  logic          out_valid;
  logic          out_ready;
  cnt_t          out_inum;
  len_t [BS-1:0] out_ilen;
  pos_t [BS-1:0] out_ipos;
  cnt_t [BS-1:0] out_psum;
  logic          out_last;

  modport slave (
    input  in_valid,
    input  in_len,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_inum,
    output out_ilen,
    output out_ipos,
    output out_psum,
    output out_last
  );

  modport master (
    output in_valid,
    output in_len,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_inum,
    input  out_ilen,
    input  out_ipos,
    input  out_psum,
    input  out_last
  );

endinterface

// File: rtl/plen_sched.sv
// Packs variable-length fields into BS-lane blocks, splitting
// fields across block boundaries into head and carry slots.
module plen_sched
  import plen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  plen_sched_if.slave bus
);

  localparam cnt_t BS_C = cnt_t'(BS);

  state_t r_state;
  state_t w_nxt_state;
  blk_t   r_acc;
  blk_t   w_nxt_acc;
  blk_t   r_hold;
  blk_t   w_nxt_hold;
  blk_t   w_blk;
  cnt_t   r_fill;
  cnt_t   w_nxt_fill;
  logic   r_ovalid;
  logic   w_nxt_ovalid;

  logic   w_free;
  logic   w_fire;
  logic   w_nz;
  logic   w_split;
  logic   w_done;
  logic   w_grow;
  logic   w_tail;
  cnt_t   w_sum;
  cnt_t   w_head;
  cnt_t   w_cy;
  pos_t   w_slot;

  assign w_free       = !r_ovalid || bus.out_ready;
  assign bus.in_ready = (r_state == ACC) && w_free;

  assign bus.out_valid = r_ovalid;
  assign bus.out_inum  = r_hold.inum;
  assign bus.out_ilen  = r_hold.ilen;
  assign bus.out_ipos  = r_hold.ipos;
  assign bus.out_psum  = r_hold.psum;
  assign bus.out_last  = r_hold.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ACC;
      r_acc    <= '0;
      r_fill   <= '0;
      r_hold   <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_acc    <= w_nxt_acc;
      r_fill   <= w_nxt_fill;
      r_hold   <= w_nxt_hold;
      r_ovalid <= w_nxt_ovalid;
    end
  end

  always_comb begin
    w_fire  = bus.in_valid && bus.in_ready;
    w_nz    = bus.in_len != '0;
    w_sum   = r_fill + cnt_t'(bus.in_len);
    w_head  = BS_C - r_fill;
    w_cy    = cnt_t'(bus.in_len) - w_head;
    w_split = w_nz && (w_sum > BS_C);
    w_done  = w_fire &&
              ((w_nz && (w_sum >= BS_C)) || bus.in_last);
    w_grow  = w_fire && !w_done;
    w_tail  = (r_state == TAIL) && w_free;
    w_slot  = pos_t'(r_acc.inum);

    // accumulator with the incoming field's slot appended
    w_blk      = r_acc;
    w_blk.last = bus.in_last && !w_split;
    if (w_nz) begin
      w_blk.ilen[w_slot] = w_split ? len_t'(w_head) : bus.in_len;
      w_blk.ipos[w_slot] = '0;
      w_blk.psum[w_slot] = w_split ? BS_C : w_sum;
      w_blk.inum         = r_acc.inum + 1'b1;
    end

    w_nxt_state  = r_state;
    w_nxt_acc    = r_acc;
    w_nxt_fill   = r_fill;
    w_nxt_hold   = r_hold;
    w_nxt_ovalid = r_ovalid && !bus.out_ready;

    unique case (1'b1)
      w_tail: begin
        w_nxt_hold      = r_acc;
        w_nxt_hold.last = 1'b1;
        w_nxt_ovalid    = 1'b1;
        w_nxt_acc       = '0;
        w_nxt_fill      = '0;
        w_nxt_state     = ACC;
      end
      w_done: begin
        w_nxt_hold   = w_blk;
        w_nxt_ovalid = 1'b1;
        w_nxt_acc    = '0;
        w_nxt_fill   = '0;
        if (w_split) begin
          w_nxt_acc.inum    = cnt_t'(1);
          w_nxt_acc.ilen[0] = len_t'(w_cy);
          w_nxt_acc.ipos[0] = pos_t'(w_head);
          w_nxt_acc.psum[0] = w_cy;
          w_nxt_fill        = w_cy;
          if (bus.in_last) begin
            w_nxt_state = TAIL;
          end
        end
      end
      w_grow: begin
        w_nxt_acc      = w_blk;
        w_nxt_acc.last = 1'b0;
        w_nxt_fill     = w_sum;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_plen_sched.sv
// Randomized and directed bench for plen_sched against a
// lane-list model of block packing.
module tb_plen_sched;
  import plen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  plen_sched_if bus ();

  plen_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  blk_t exp_q[$];
  int   m_len[$];
  int   m_pos[$];
  int   m_fill = 0;
  bit   ovnext = 1'b0;

  task automatic check(string tag, logic [191:0] got,
                       logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m_len.delete();
    m_pos.delete();
    m_fill = 0;
  endtask

  task automatic m_emit(bit last);
    blk_t b;
    int   ps;
    b  = '0;
    ps = 0;
    b.inum = cnt_t'(m_len.size());
    foreach (m_len[j]) begin
      ps += m_len[j];
      b.ilen[j] = len_t'(m_len[j]);
      b.ipos[j] = pos_t'(m_pos[j]);
      b.psum[j] = cnt_t'(ps);
    end
    b.last = last;
    exp_q.push_back(b);
    m_clear();
    ovnext = 1'b1;
  endtask

  // a field fills lanes; a full block is cut and any rest
  // starts the next block at its offset within the field
  task automatic m_accept(int L, bit last);
    bit closed;
    int take;
    closed = 1'b0;
    if (L > 0) begin
      take = (L < BS - m_fill) ? L : BS - m_fill;
      m_len.push_back(take);
      m_pos.push_back(0);
      m_fill += take;
      if (m_fill == BS) begin
        m_emit(last && take == L);
        closed = (take == L);
        if (take < L) begin
          m_len.push_back(L - take);
          m_pos.push_back(take);
          m_fill = L - take;
        end
      end
    end
    if (last && !closed) m_emit(1'b1);
  endtask

  task automatic sb_pop();
    blk_t e;
    if (exp_q.size() == 0) begin
      check("spurious_blk", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("inum", bus.out_inum, e.inum);
    check("ilen", bus.out_ilen, e.ilen);
    check("ipos", bus.out_ipos, e.ipos);
    check("psum", bus.out_psum, e.psum);
    check("last", bus.out_last, e.last);
  endtask

  task automatic step(bit v, int L, bit last, bit rdy,
                      output bit acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_len    = len_t'(L);
    bus.in_last   = last;
    bus.out_ready = rdy;
    #4;
    if (ovnext) begin
      check("lat_ovalid", bus.out_valid, 1);
      ovnext = 1'b0;
    end
    acc = v && bus.in_ready;
    if (bus.out_valid && rdy) sb_pop();
    if (acc) m_accept(L, last);
  endtask

  task automatic send(int L, bit last, bit rdy);
    bit a;
    int n;
    n = 0;
    do begin
      step(1'b1, L, last, rdy, a);
      n++;
    end while (!a && n < 50);
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      step(1'b0, 0, 1'b0, 1'b1, a);
      n++;
    end
    check("drain_q", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    exp_q.delete();
    ovnext = 1'b0;
    #1;
    check("rst_ovalid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_inum", bus.out_inum, 0);
    check("rst_ilen", bus.out_ilen, 0);
    check("rst_ipos", bus.out_ipos, 0);
    check("rst_psum", bus.out_psum, 0);
  endtask

  initial begin
    bit           a;
    cnt_t [BS-1:0] snap_psum;
    len_t [BS-1:0] snap_ilen;
    bus.in_valid  = 1'b0;
    bus.in_len    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

    for (int i = 0; i < 5; i++) send(3, 1'b0, 1'b1);
    do_reset();
    send(7, 1'b1, 1'b1);
    drain();

    for (int i = 0; i < 32; i++) send(1, 1'b0, 1'b1);
    drain();

    send(15, 1'b0, 1'b1);
    send(15, 1'b0, 1'b1);
    send(7, 1'b0, 1'b1);
    send(0, 1'b1, 1'b1);
    drain();

    send(15, 1'b0, 1'b1);
    send(15, 1'b0, 1'b1);
    send(7, 1'b1, 1'b1);
    step(1'b1, 4, 1'b0, 1'b1, a);
    check("tail_ready", bus.in_ready, 0);
    check("tail_acc", a, 0);
    drain();

    send(15, 1'b0, 1'b0);
    send(15, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 9, 1'b0, 1'b0, a);
      if (i == 0) begin
        snap_psum = bus.out_psum;
        snap_ilen = bus.out_ilen;
      end
      check("bp_ready", bus.in_ready, 0);
      check("bp_acc", a, 0);
      check("bp_psum", bus.out_psum, snap_psum);
      check("bp_ilen", bus.out_ilen, snap_ilen);
    end
    send(9, 1'b0, 1'b1);
    send(9, 1'b0, 1'b1);
    send(9, 1'b0, 1'b1);
    send(5, 1'b0, 1'b1);
    drain();

    send(0, 1'b0, 1'b1);
    send(3, 1'b0, 1'b1);
    send(0, 1'b0, 1'b1);
    send(4, 1'b1, 1'b1);
    drain();
    send(0, 1'b1, 1'b1);
    drain();

    for (int i = 0; i < 3000; i++) begin
      step(1'b1 & $urandom_range(0, 1),
           $urandom_range(0, 15),
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, a);
    end
    send(0, 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
